// File: rtl/bcd_counter_modn.sv
// bcd_counter_modn: two-digit BCD counter. It counts modulo MODULUS, up or down.
// It has an enable input and a synchronous parallel load.
// Tc is combinational and meant to feed the En of the next cascaded stage,
// so a chain such as 60 -> 60 -> 24 rolls over entirely on a single edge.
// Priority at each rising edge: RST > Load > En > hold.
module bcd_counter_modn #(
    parameter int MODULUS   = 60,   // count range 0..MODULUS-1, legal 2..100
    parameter int RESET_VAL = 0     // must be < MODULUS
) (
    input  logic       Clk_2,
    input  logic       RST,
    input  logic       En,
    input  logic       Up,
    input  logic       Load,
    input  logic [3:0] Load_tens,
    input  logic [3:0] Load_digits,
    output logic [3:0] tens,
    output logic [3:0] digits,
    output logic       Tc,
    output logic       Load_err
);

    // Top of range and reset value, pre-split into BCD fields
    localparam logic [3:0] MAX_TENS   = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] MAX_DIGITS = 4'((MODULUS - 1) % 10);
    localparam logic [3:0] RST_TENS   = 4'(RESET_VAL / 10);
    localparam logic [3:0] RST_DIGITS = 4'(RESET_VAL % 10);
    localparam logic [6:0] MAX_VAL    = 7'(MODULUS - 1);
    localparam logic [6:0] MOD_VAL    = 7'(MODULUS);

    logic [3:0] r_tens;
    logic [3:0] r_digits;
    logic       r_load_err;

    logic [6:0] w_value;
    logic [6:0] w_load_value;
    logic       w_load_ok;
    logic       w_at_max;
    logic       w_at_zero;
    logic [3:0] w_next_tens;
    logic [3:0] w_next_digits;
    logic       w_next_err;

    // Binary view of the current count and of the load request.
    // w_load_value can overflow when a field holds A-F. w_load_ok masks that
    // case, because the per-field range checks are applied first.
    assign w_value      = ({3'b000, r_tens} * 7'd10) + {3'b000, r_digits};
    assign w_load_value = ({3'b000, Load_tens} * 7'd10) + {3'b000, Load_digits};
    assign w_load_ok    = (Load_tens <= 4'd9) && (Load_digits <= 4'd9) &&
                          (w_load_value < MOD_VAL);
    assign w_at_max     = (w_value == MAX_VAL);
    assign w_at_zero    = (w_value == 7'd0);

    // Next count and load-error flag. The priority is Load, then En, then hold.
    // RST is applied in the register.
    always_comb begin
        w_next_tens   = r_tens;
        w_next_digits = r_digits;
        w_next_err    = 1'b0;
        if (Load) begin
            if (w_load_ok) begin
                w_next_tens   = Load_tens;
                w_next_digits = Load_digits;
            end else begin
                w_next_err    = 1'b1;   // rejected load: hold the count and flag it
            end
        end else if (En) begin
            if (Up) begin
                if (w_at_max) begin
                    w_next_tens   = 4'd0;
                    w_next_digits = 4'd0;
                end else if (r_digits == 4'd9) begin
                    w_next_tens   = r_tens + 4'd1;
                    w_next_digits = 4'd0;
                end else begin
                    w_next_digits = r_digits + 4'd1;
                end
            end else begin
                if (w_at_zero) begin
                    w_next_tens   = MAX_TENS;
                    w_next_digits = MAX_DIGITS;
                end else if (r_digits == 4'd0) begin
                    w_next_tens   = r_tens - 4'd1;
                    w_next_digits = 4'd9;
                end else begin
                    w_next_digits = r_digits - 4'd1;
                end
            end
        end
    end

    // Count and error registers with synchronous reset
    always_ff @(posedge Clk_2) begin
        if (RST) begin
            r_tens     <= RST_TENS;
            r_digits   <= RST_DIGITS;
            r_load_err <= 1'b0;
        end else begin
            r_tens     <= w_next_tens;
            r_digits   <= w_next_digits;
            r_load_err <= w_next_err;
        end
    end

    assign tens     = r_tens;
    assign digits   = r_digits;
    assign Load_err = r_load_err;
    assign Tc       = En & ~Load & ~RST & (Up ? w_at_max : w_at_zero);

endmodule

// File: doc/bcd_counter_modn.md
Name: bcd_counter_modn

Overview:
- Parametrised two-digit BCD counter, modulus MODULUS (2..100), counting up or down with enable and synchronous parallel load.
- Terminal-count output cascades instances on one clock, e.g. seconds (60) -> minutes (60) -> hours (24) in the clock/timer display path.
- tens/digits drive the 7-segment decoder directly. The count register is the output; there is no binary-to-BCD lag.

Parameters:
- MODULUS, 60, count range 0..MODULUS-1; legal 2..100.
- RESET_VAL, 0, value loaded on reset; must be < MODULUS.

Ports:
- Clk_2, input, 1, counter clock; all state changes on its rising edge.
- RST, input, 1, synchronous active-high reset.
- En, input, 1, count enable; one step per cycle while high.
- Up, input, 1, direction: 1 = increment, 0 = decrement.
- Load, input, 1, synchronous parallel load request.
- Load_tens, input, 4, BCD tens value to load.
- Load_digits, input, 4, BCD units value to load.
- tens, output, 4, BCD tens of current count.
- digits, output, 4, BCD units of current count.
- Tc, output, 1, terminal count (combinational).
- Load_err, output, 1, registered one-cycle pulse: load rejected.

Behaviour:
- Value V = 10*tens + digits. Always 0 <= V < MODULUS. digits is always <= 9.
- Reset: when RST is high at a rising edge, tens/digits = RESET_VAL in BCD and Load_err = 0. RST overrides Load and En.
- Priority at each edge: RST > Load > En > hold.
- Valid load: Load=1, Load_digits <= 9, Load_tens <= 9, and 10*Load_tens + Load_digits < MODULUS.
  - Next V = loaded value.
  - Load_err = 0 next cycle.
- Invalid load: Load=1 with any of the conditions above failing.
  - Count holds.
  - Load_err = 1 for exactly one cycle.
  - En is ignored that cycle; Load still has priority.
- Load_err = 0 in every cycle without a rejected load.
- Count up (En=1, Up=1, Load=0):
  - digits increments.
  - digits 9 -> 0 with tens+1.
  - V = MODULUS-1 -> 00 (wrap).
- Count down (En=1, Up=0, Load=0):
  - digits decrements.
  - digits 0 -> 9 with tens-1.
  - V = 00 -> MODULUS-1 in BCD (wrap).
- Hold: En=0 and Load=0 keeps the count.
- Tc = En & ~Load & ~RST & (Up ? V==MODULUS-1 : V==0).
  - Asserts in the same cycle as the wrapping edge, so Tc feeds the next stage's En directly.
  - Tc is never high while Load or RST is asserted.
- Up may change on any cycle and takes effect on the next enabled edge. There is no direction-change penalty.
- MODULUS <= 10: tens stays 0. Wrap compares against MODULUS-1 only.
- Latency: all outputs except Tc are registered, one cycle from the input edge. Tc is zero-latency combinational.
- Comparisons use a 7-bit value; no BCD field ever holds A-F.

Test Plan:
- Reset/count up, MODULUS=60: RST 1 cycle, then En=1, Up=1 for 61 edges.
  - Required: 00,01..09,10..59,00.
  - Tc=1 only in the cycle V=59.
  - Load_err stays 0.
- Count down wrap: from 00 with En=1, Up=0.
  - Required: Tc=1 at 00, next value 59, then 58.
  - 50 -> 49 borrows correctly.
- Load, with En=1, Up=1:
  - Load=1, 4/5 -> 45 next cycle; count continues 46.
  - Load 6/5 (65 >= 60) -> count holds, Load_err pulses 1 cycle.
  - Load 3/A -> same rejection.
  - Load=1 with V=59 -> Tc=0.
- Cascade, MODULUS=24 instance: preset 23, En=1, Up=1.
  - Required: next 00, Tc high in the 23 cycle.
  - Chained 60->60->24 chain from 23:59:59 rolls to 00:00:00 in one edge.
- Reset mid-operation, RESET_VAL=12: assert RST at V=37 with Load=1 and En=1.
  - Required: next value 12, Load_err=0, Tc=0 during RST.
- Hold: En=0 for 5 cycles at V=30.
  - Required: value stays 30, Tc=0; toggling Up has no effect.
